// File: rtl/sap1_fetch_unit.sv
// SAP-1 fetch datapath: program counter, memory address register, 16x8 program RAM,
// instruction register and the shared 8-bit bus multiplexer.
module sap1_fetch_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] ctrl_word,
  input  logic        hlt_i,
  input  logic [7:0]  bus_i,
  input  logic        prog_mode_i,
  input  logic        prog_we_i,
  input  logic [3:0]  prog_addr_i,
  input  logic [7:0]  prog_data_i,
  output logic [7:0]  bus_o,
  output logic [3:0]  opcode_o,
  output logic [3:0]  pc_o,
  output logic [3:0]  mar_o,
  output logic        bus_conflict_o
);

  logic       incr_pc, pc_en, mar_load_n, ram_en_n, instr_load_n, instr_en_n;
  logic       unused_ctrl;
  logic [3:0] pc_q, pc_d;
  logic [3:0] mar_q, mar_d;
  logic [7:0] ir_q, ir_d;
  logic       conflict_q, conflict_d;
  logic [7:0] ram_q [16];
  logic       run_en;
  logic [1:0] n_drivers;

  assign incr_pc      = ctrl_word[0];
  assign pc_en        = ctrl_word[1];
  assign mar_load_n   = ctrl_word[2];
  assign ram_en_n     = ctrl_word[3];
  assign instr_load_n = ctrl_word[4];
  assign instr_en_n   = ctrl_word[5];
  assign unused_ctrl  = ^ctrl_word[11:6];

  // Priority mux: PC, then RAM, then IR operand, then external drivers.
  always_comb begin
    bus_o = bus_i;
    if (pc_en) begin
      bus_o = {4'h0, pc_q};
    end else if (!ram_en_n) begin
      bus_o = ram_q[mar_q];
    end else if (!instr_en_n) begin
      bus_o = {4'h0, ir_q[3:0]};
    end
  end

  always_comb begin
    run_en     = !prog_mode_i && hlt_i;
    n_drivers  = {1'b0, pc_en} + {1'b0, !ram_en_n} + {1'b0, !instr_en_n};
    pc_d       = pc_q;
    mar_d      = mar_q;
    ir_d       = ir_q;
    // Conflict is tracked in run mode even while halted.
    conflict_d = conflict_q | (!prog_mode_i && (n_drivers >= 2'd2));
    if (run_en) begin
      if (incr_pc) begin
        pc_d = pc_q + 4'd1;
      end
      if (!mar_load_n) begin
        mar_d = bus_o[3:0];
      end
      if (!instr_load_n) begin
        ir_d = bus_o;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= 4'h0;
      mar_q      <= 4'h0;
      ir_q       <= 8'h00;
      conflict_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      ir_q       <= ir_d;
      conflict_q <= conflict_d;
    end
  end

  // RAM is not reset; a programming write completes even on a reset edge.
  always_ff @(posedge clk_i) begin
    if (prog_mode_i && prog_we_i) begin
      ram_q[prog_addr_i] <= prog_data_i;
    end
  end

  assign opcode_o       = ir_q[7:4];
  assign pc_o           = pc_q;
  assign mar_o          = mar_q;
  assign bus_conflict_o = conflict_q;

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Directed self-checking bench for sap1_fetch_unit: fetch, wrap, freeze, conflict, reset.
module tb_sap1_fetch_unit;

  logic        clk;
  logic        rst;
  logic [11:0] ctrl;
  logic        hlt;
  logic [7:0]  bus_in;
  logic        prog_mode, prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [7:0]  bus_out;
  logic [3:0]  opcode, pc, mar;
  logic        conflict;

  int checks = 0;
  int fails  = 0;

  sap1_fetch_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ctrl_word      (ctrl),
    .hlt_i          (hlt),
    .bus_i          (bus_in),
    .prog_mode_i    (prog_mode),
    .prog_we_i      (prog_we),
    .prog_addr_i    (prog_addr),
    .prog_data_i    (prog_data),
    .bus_o          (bus_out),
    .opcode_o       (opcode),
    .pc_o           (pc),
    .mar_o          (mar),
    .bus_conflict_o (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arguments are "asserted" flags; active-low bits are inverted here. Upper bits are junk.
  function automatic logic [11:0] cw(input logic incr, input logic pc_en, input logic mar_ld,
                                     input logic ram_rd, input logic ir_ld, input logic ir_en);
    return {6'b101101, ~ir_en, ~ir_ld, ~ram_rd, ~mar_ld, pc_en, incr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    prog_mode = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0; prog_mode = 1'b0;
  endtask

  task automatic do_reset();
    ctrl = cw(0, 0, 0, 0, 0, 0); rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus_in = 8'h5A;
    #1;
    checks++; if (pc !== 4'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", pc); end
    checks++; if (mar !== 4'h0) begin fails++; $display("FAIL reset_mar got %h exp 0", mar); end
    checks++; if (opcode !== 4'h0) begin fails++; $display("FAIL reset_opcode got %h exp 0", opcode); end
    checks++; if (conflict !== 1'b0) begin fails++; $display("FAIL reset_conflict got %b exp 0", conflict); end
    checks++; if (bus_out !== 8'h5A) begin fails++; $display("FAIL reset_bus_ext got %h exp 5a", bus_out); end
    ctrl = cw(0, 0, 0, 0, 0, 1); #1;
    checks++; if (bus_out !== 8'h00) begin fails++; $display("FAIL reset_ir_low got %h exp 00", bus_out); end
    ctrl = cw(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_program_fetch();
    prog_write(4'd0, 8'h1E);
    prog_write(4'd14, 8'h05);
    ctrl = cw(0, 1, 1, 0, 0, 0); tick();   // T1
    checks++; if (mar !== 4'h0) begin fails++; $display("FAIL t1_mar got %h exp 0", mar); end
    ctrl = cw(1, 0, 0, 0, 0, 0); tick();   // T2
    checks++; if (pc !== 4'h1) begin fails++; $display("FAIL t2_pc got %h exp 1", pc); end
    ctrl = cw(0, 0, 0, 1, 1, 0); #1;       // T3
    checks++; if (bus_out !== 8'h1E) begin fails++; $display("FAIL t3_bus got %h exp 1e", bus_out); end
    tick();
    checks++; if (opcode !== 4'h1) begin fails++; $display("FAIL t3_opcode got %h exp 1", opcode); end
    ctrl = cw(0, 0, 1, 0, 0, 1); #1;
    checks++; if (bus_out !== 8'h0E) begin fails++; $display("FAIL ir_operand_bus got %h exp 0e", bus_out); end
    tick();
    checks++; if (mar !== 4'hE) begin fails++; $display("FAIL operand_mar got %h exp e", mar); end
    ctrl = cw(0, 0, 0, 1, 0, 0); #1;
    checks++; if (bus_out !== 8'h05) begin fails++; $display("FAIL ram14_bus got %h exp 05", bus_out); end
    ctrl = cw(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    ctrl = cw(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    checks++; if (pc !== 4'hF) begin fails++; $display("FAIL wrap_pc15 got %h exp f", pc); end
    tick();
    checks++; if (pc !== 4'h0) begin fails++; $display("FAIL wrap_pc0 got %h exp 0", pc); end
    ctrl = cw(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_freeze();
    ctrl = cw(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    bus_in = 8'h69; ctrl = cw(1, 0, 1, 0, 1, 0); tick();
    checks++; if (pc !== 4'h6 || mar !== 4'h9 || opcode !== 4'h6) begin
      fails++; $display("FAIL freeze_setup got pc=%h mar=%h op=%h exp 6 9 6", pc, mar, opcode);
    end
    bus_in = 8'hF0; hlt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (pc !== 4'h6 || mar !== 4'h9 || opcode !== 4'h6) begin
      fails++; $display("FAIL halt_hold got pc=%h mar=%h op=%h exp 6 9 6", pc, mar, opcode);
    end
    hlt = 1'b1; prog_mode = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (pc !== 4'h6 || mar !== 4'h9 || opcode !== 4'h6) begin
      fails++; $display("FAIL prog_hold got pc=%h mar=%h op=%h exp 6 9 6", pc, mar, opcode);
    end
    prog_mode = 1'b0; ctrl = cw(0, 0, 0, 0, 0, 1); #1;
    checks++; if (bus_out !== 8'h09) begin fails++; $display("FAIL freeze_ir_low got %h exp 09", bus_out); end
    ctrl = cw(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_bus_conflict();
    do_reset();
    prog_write(4'd3, 8'hAA);
    bus_in = 8'h03; ctrl = cw(1, 0, 1, 0, 0, 0); tick();
    ctrl = cw(1, 0, 0, 0, 0, 0); tick(); tick();
    checks++; if (pc !== 4'h3 || mar !== 4'h3) begin
      fails++; $display("FAIL conflict_setup got pc=%h mar=%h exp 3 3", pc, mar);
    end
    ctrl = cw(0, 1, 0, 1, 0, 0); #1;
    checks++; if (bus_out !== 8'h03) begin fails++; $display("FAIL conflict_bus got %h exp 03", bus_out); end
    checks++; if (conflict !== 1'b0) begin fails++; $display("FAIL conflict_pre got %b exp 0", conflict); end
    tick();
    checks++; if (conflict !== 1'b1) begin fails++; $display("FAIL conflict_set got %b exp 1", conflict); end
    ctrl = cw(0, 0, 0, 0, 0, 0); tick(); tick();
    checks++; if (conflict !== 1'b1) begin fails++; $display("FAIL conflict_sticky got %b exp 1", conflict); end
    do_reset();
    checks++; if (conflict !== 1'b0) begin fails++; $display("FAIL conflict_clear got %b exp 0", conflict); end
  endtask

  task automatic test_reset_mid();
    ctrl = cw(0, 1, 1, 0, 0, 0); tick();
    ctrl = cw(1, 0, 0, 0, 0, 0); tick();
    ctrl = cw(0, 0, 0, 1, 1, 0);
    rst = 1'b1; prog_mode = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'h77;
    tick();
    rst = 1'b0; prog_mode = 1'b0; prog_we = 1'b0;
    checks++; if (pc !== 4'h0 || mar !== 4'h0 || opcode !== 4'h0) begin
      fails++; $display("FAIL mid_reset got pc=%h mar=%h op=%h exp 0 0 0", pc, mar, opcode);
    end
    ctrl = cw(0, 0, 0, 0, 0, 1); #1;
    checks++; if (bus_out !== 8'h00) begin fails++; $display("FAIL mid_reset_ir got %h exp 00", bus_out); end
    bus_in = 8'h02; ctrl = cw(0, 0, 1, 0, 0, 0); tick();
    ctrl = cw(0, 0, 0, 1, 0, 0); #1;
    checks++; if (bus_out !== 8'h77) begin fails++; $display("FAIL mid_reset_ram got %h exp 77", bus_out); end
    ctrl = cw(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_external_bus();
    bus_in = 8'h3C; ctrl = cw(0, 0, 1, 0, 0, 0); #1;
    checks++; if (bus_out !== 8'h3C) begin fails++; $display("FAIL ext_bus got %h exp 3c", bus_out); end
    tick();
    checks++; if (mar !== 4'hC) begin fails++; $display("FAIL ext_mar got %h exp c", mar); end
    checks++; if (conflict !== 1'b0) begin fails++; $display("FAIL ext_conflict got %b exp 0", conflict); end
    ctrl = cw(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; ctrl = 12'h03C; hlt = 1'b1; bus_in = 8'h00;
    prog_mode = 1'b0; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    test_reset();
    test_program_fetch();
    test_wrap();
    test_freeze();
    test_bus_conflict();
    test_reset_mid();
    test_external_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
